bayer_mosaic: RTL and testbench

BAYER_MOSAIC -- requirements
Module: bayer_mosaic

---
 rtl/bayer_mosaic.sv | 168 ++++++++++++++++
 tb/tb_bayer_mosaic.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bayer_mosaic.sv
// Converts an RGB pixel stream into a single-channel RAW Bayer mosaic stream,
// tracking frame position and flagging incomplete or over-long frames.
module bayer_mosaic #(
  parameter int         H_ACTIVE = 1280,
  parameter int         V_ACTIVE = 1024,
  parameter logic [1:0] PATTERN  = 2'd1
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iFVAL,
  input  logic        iDVAL,
  input  logic [11:0] iRed,
  input  logic [11:0] iGreen,
  input  logic [11:0] iBlue,
  output logic [11:0] oDATA,
  output logic        oDVAL,
  output logic [10:0] oX_Cont,
  output logic [10:0] oY_Cont,
  output logic        oFRAME_DONE,
  output logic        oERR
);

  localparam int          DATA_W = 12;
  localparam logic [10:0] X_LAST = 11'(H_ACTIVE - 1);
  localparam logic [10:0] Y_LAST = 11'(V_ACTIVE - 1);
  localparam logic [1:0]  CH_R   = 2'd0;
  localparam logic [1:0]  CH_G   = 2'd1;
  localparam logic [1:0]  CH_B   = 2'd2;

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  // Colour order packed site3..site0 so the site index selects a 2-bit field.
  function automatic logic [1:0] siteChannel(input logic [1:0] pat, input logic [1:0] site);
    logic [7:0] order;
    case (pat)
      2'd0:    order = {CH_B, CH_G, CH_G, CH_R};
      2'd1:    order = {CH_G, CH_B, CH_R, CH_G};
      2'd2:    order = {CH_G, CH_R, CH_B, CH_G};
      default: order = {CH_R, CH_G, CH_G, CH_B};
    endcase
    return order[{site, 1'b0} +: 2];
  endfunction

  function automatic logic [DATA_W-1:0] pickSample(input logic [1:0] ch,
                                                    input logic [DATA_W-1:0] r,
                                                    input logic [DATA_W-1:0] g,
                                                    input logic [DATA_W-1:0] b);
    case (ch)
      CH_R:    return r;
      CH_G:    return g;
      default: return b;
    endcase
  endfunction

  state_t      state, stateNext;
  logic        fvalPrev;
  logic        errSent, errSentNext;
  logic [10:0] xCnt, yCnt, xNext, yNext;

  logic              fvalRise;
  logic              lastPix;
  logic              vld_p0;
  logic              frameDone_p0;
  logic              err_p0;
  logic [DATA_W-1:0] pix_p0;

  assign fvalRise = iFVAL & ~fvalPrev;
  assign lastPix  = (xCnt == X_LAST) && (yCnt == Y_LAST);
  assign pix_p0   = pickSample(siteChannel(PATTERN, {yCnt[0], xCnt[0]}), iRed, iGreen, iBlue);

  // Stage p0: acceptance decision, counter advance and next state
  always_comb begin
    stateNext    = state;
    xNext        = xCnt;
    yNext        = yCnt;
    errSentNext  = errSent;
    vld_p0       = 1'b0;
    frameDone_p0 = 1'b0;
    err_p0       = 1'b0;
    case (state)
      IDLE: begin
        xNext       = '0;
        yNext       = '0;
        errSentNext = 1'b0;
        if (fvalRise) begin
          stateNext = ACTIVE;
          vld_p0    = iDVAL;
        end
      end
      ACTIVE: begin
        if (!iFVAL) begin
          // A final pixel arriving with the falling edge still completes the frame.
          if (iDVAL && lastPix) begin
            vld_p0 = 1'b1;
          end else begin
            err_p0    = 1'b1;
            stateNext = IDLE;
            xNext     = '0;
            yNext     = '0;
          end
        end else begin
          vld_p0 = iDVAL;
        end
      end
      DONE: begin
        if (!iFVAL) begin
          stateNext = IDLE;
        end else if (iDVAL && !errSent) begin
          err_p0      = 1'b1;
          errSentNext = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase

    if (vld_p0) begin
      if (lastPix) begin
        frameDone_p0 = 1'b1;
        xNext        = '0;
        yNext        = '0;
        stateNext    = iFVAL ? DONE : IDLE;
      end else if (xCnt == X_LAST) begin
        xNext = '0;
        yNext = yCnt + 11'd1;
      end else begin
        xNext = xCnt + 11'd1;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state    <= IDLE;
      fvalPrev <= 1'b0;
      errSent  <= 1'b0;
      xCnt     <= '0;
      yCnt     <= '0;
    end else begin
      state    <= stateNext;
      fvalPrev <= iFVAL;
      errSent  <= errSentNext;
      xCnt     <= xNext;
      yCnt     <= yNext;
    end
  end

  // Stage p1: registered outputs; data and position hold between valid pixels
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oDVAL       <= 1'b0;
      oFRAME_DONE <= 1'b0;
      oERR        <= 1'b0;
      oDATA       <= '0;
      oX_Cont     <= '0;
      oY_Cont     <= '0;
    end else begin
      oDVAL       <= vld_p0;
      oFRAME_DONE <= frameDone_p0;
      oERR        <= err_p0;
      if (vld_p0) begin
        oDATA   <= pix_p0;
        oX_Cont <= xCnt;
        oY_Cont <= yCnt;
      end
    end
  end

endmodule

// File: tb/tb_bayer_mosaic.sv
// Directed scoreboard bench for bayer_mosaic: a 4x2 GRBG instance for framing
// behaviour plus four 2x2 instances, one per CFA phase.
module tb_bayer_mosaic;

  logic        iCLK = 1'b0;
  logic        iRST, iFVAL, iDVAL, pF, pD;
  logic [11:0] iRed, iGreen, iBlue;
  logic [11:0] oDATA;
  logic        oDVAL, oFRAME_DONE, oERR;
  logic [10:0] oX_Cont, oY_Cont;

  logic [11:0] pData [4];
  logic        pDval [4];
  logic        pFd   [4];
  logic        pErr  [4];
  logic [10:0] pX    [4];
  logic [10:0] pY    [4];

  typedef struct {
    logic [11:0] d;
    logic [10:0] x;
    logic [10:0] y;
    logic        fd;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        pq[4][$];
  int          nTests = 0, nFail = 0, errCnt = 0, cyc = 0, errBase;
  logic [11:0] lastD = '0;
  logic [10:0] lastX = '0, lastY = '0;
  bit          fixedRgb = 0;

  always #5 iCLK = ~iCLK;
  always @(posedge iCLK) cyc <= cyc + 1;

  bayer_mosaic #(.H_ACTIVE(4), .V_ACTIVE(2), .PATTERN(2'd1)) dut (
    .iCLK(iCLK), .iRST(iRST), .iFVAL(iFVAL), .iDVAL(iDVAL),
    .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .oDATA(oDATA), .oDVAL(oDVAL), .oX_Cont(oX_Cont), .oY_Cont(oY_Cont),
    .oFRAME_DONE(oFRAME_DONE), .oERR(oERR)
  );

  for (genvar p = 0; p < 4; p++) begin : g_pat
    bayer_mosaic #(.H_ACTIVE(2), .V_ACTIVE(2), .PATTERN(2'(p))) dutPat (
      .iCLK(iCLK), .iRST(iRST), .iFVAL(pF), .iDVAL(pD),
      .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
      .oDATA(pData[p]), .oDVAL(pDval[p]), .oX_Cont(pX[p]), .oY_Cont(pY[p]),
      .oFRAME_DONE(pFd[p]), .oERR(pErr[p])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference CFA table: which colour lands on site {y[0],x[0]}.
  function automatic logic [11:0] expPix(input int pat, input int x, input int y,
                                         input logic [11:0] r, input logic [11:0] g,
                                         input logic [11:0] b);
    int s;
    s = (y % 2) * 2 + (x % 2);
    case (pat)
      0:       return (s == 0) ? r : (s == 3) ? b : g;
      1:       return (s == 1) ? r : (s == 2) ? b : g;
      2:       return (s == 2) ? r : (s == 1) ? b : g;
      default: return (s == 3) ? r : (s == 0) ? b : g;
    endcase
  endfunction

  always @(negedge iCLK) begin
    exp_t e;
    if (oDVAL) begin
      if (q.size() == 0) check("spurious_dval", 32'(oDVAL), 32'd0);
      else begin
        e = q.pop_front();
        check("data", 32'(oDATA), 32'(e.d));
        check("xcont", 32'(oX_Cont), 32'(e.x));
        check("ycont", 32'(oY_Cont), 32'(e.y));
        check("frame_done", 32'(oFRAME_DONE), 32'(e.fd));
        check("latency", 32'(cyc), 32'(e.cyc));
        lastD = oDATA; lastX = oX_Cont; lastY = oY_Cont;
      end
    end else begin
      check("hold_data", 32'(oDATA), 32'(lastD));
      check("hold_x", 32'(oX_Cont), 32'(lastX));
      check("hold_y", 32'(oY_Cont), 32'(lastY));
      check("fd_idle", 32'(oFRAME_DONE), 32'd0);
    end
    if (oERR) errCnt++;
  end

  always @(negedge iCLK) begin
    exp_t e;
    for (int p = 0; p < 4; p++) begin
      if (pDval[p]) begin
        if (pq[p].size() == 0) check($sformatf("pat%0d_spurious", p), 32'(pDval[p]), 32'd0);
        else begin
          e = pq[p].pop_front();
          check($sformatf("pat%0d_data", p), 32'(pData[p]), 32'(e.d));
          check($sformatf("pat%0d_fd", p), 32'(pFd[p]), 32'(e.fd));
          check($sformatf("pat%0d_lat", p), 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic drive(input bit f, input bit d);
    @(negedge iCLK);
    iFVAL = f;
    iDVAL = d;
    if (fixedRgb) begin
      iRed = 12'h100; iGreen = 12'h200; iBlue = 12'h300;
    end else begin
      iRed = 12'($urandom); iGreen = 12'($urandom); iBlue = 12'($urandom);
    end
  endtask

  task automatic px(input bit f, input bit d, input bit push, input int x, input int y,
                    input bit fd);
    exp_t e;
    drive(f, d);
    if (push) begin
      e.d = expPix(1, x, y, iRed, iGreen, iBlue);
      e.x = 11'(x); e.y = 11'(y); e.fd = fd; e.cyc = cyc + 1;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) px(0, 0, 0, 0, 0, 0);
  endtask

  task automatic frame(input bit fLast);
    for (int k = 0; k < 8; k++)
      px((k == 7) ? fLast : 1'b1, 1, 1, k % 4, k / 4, k == 7);
  endtask

  task automatic chkZero(input string tag);
    check({tag, "_data"}, 32'(oDATA), 32'd0);
    check({tag, "_dval"}, 32'(oDVAL), 32'd0);
    check({tag, "_x"}, 32'(oX_Cont), 32'd0);
    check({tag, "_y"}, 32'(oY_Cont), 32'd0);
    check({tag, "_fd"}, 32'(oFRAME_DONE), 32'd0);
    check({tag, "_err"}, 32'(oERR), 32'd0);
  endtask

  initial begin
    exp_t e;
    iRST = 1'b1; iFVAL = 0; iDVAL = 0; pF = 0; pD = 0;
    iRed = '0; iGreen = '0; iBlue = '0;
    #1 iRST = 1'b0;
    repeat (3) @(negedge iCLK);
    #1 chkZero("reset");
    @(negedge iCLK);
    iRST = 1'b1;
    idle(2);

    // GRBG reference frame with fixed colour values
    fixedRgb = 1;
    errBase = errCnt;
    frame(1);
    idle(3);
    fixedRgb = 0;

    // Alternating pixel valid
    for (int i = 0; i < 16; i++)
      px(1, (i % 2) == 0, (i % 2) == 0, (i / 2) % 4, (i / 2) / 4, i == 14);
    idle(3);
    check("no_err_clean", 32'(errCnt - errBase), 32'd0);

    // Frame valid drops after five pixels, dropped pixel with the drop
    errBase = errCnt;
    for (int k = 0; k < 5; k++) px(1, 1, 1, k % 4, k / 4, 0);
    px(0, 1, 0, 0, 0, 0);
    idle(2);
    check("early_drop_err", 32'(errCnt - errBase), 32'd1);
    frame(1);
    idle(2);

    // Extra pixels after a complete frame
    errBase = errCnt;
    frame(1);
    repeat (3) px(1, 1, 0, 0, 0, 0);
    idle(3);
    check("extra_pix_err", 32'(errCnt - errBase), 32'd1);

    // Last pixel coincident with falling frame valid, then stray pixels in IDLE
    errBase = errCnt;
    frame(0);
    repeat (3) px(0, 1, 0, 0, 0, 0);
    idle(2);
    check("coincident_no_err", 32'(errCnt - errBase), 32'd0);

    // Reset mid-frame at pixel (2,1)
    errBase = errCnt;
    for (int k = 0; k < 6; k++) px(1, 1, 1, k % 4, k / 4, 0);
    drive(1, 1);
    #2 iRST = 1'b0;
    iFVAL = 0;
    lastD = '0; lastX = '0; lastY = '0;
    q.delete();
    #1 chkZero("rst_mid");
    @(negedge iCLK);
    #1 chkZero("rst_hold");
    @(negedge iCLK);
    iRST = 1'b1;
    repeat (3) px(0, 1, 0, 0, 0, 0);
    frame(1);
    idle(3);
    check("rst_no_err", 32'(errCnt - errBase), 32'd0);

    // One 2x2 frame through each CFA phase
    for (int k = 0; k < 4; k++) begin
      @(negedge iCLK);
      pF = 1; pD = 1;
      iRed = 12'($urandom); iGreen = 12'($urandom); iBlue = 12'($urandom);
      for (int p = 0; p < 4; p++) begin
        e.d = expPix(p, k % 2, k / 2, iRed, iGreen, iBlue);
        e.x = 11'(k % 2); e.y = 11'(k / 2); e.fd = (k == 3); e.cyc = cyc + 1;
        pq[p].push_back(e);
      end
    end
    @(negedge iCLK);
    pF = 0; pD = 0;
    idle(3);

    check("main_queue_empty", 32'(q.size()), 32'd0);
    for (int p = 0; p < 4; p++)
      check($sformatf("pat%0d_queue_empty", p), 32'(pq[p].size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
